// File: rtl/cache_arbiter.sv
// cache_arbiter: two-requester round-robin arbiter in front of one four-phase cache port
// Ports: clock, reset (sync, active-low); r0_*/r1_*: request/operation/addr/wdata in, valid/evict/rdata out;
//        c_*: request/operation/addr/wdata out, rdata/valid/evict in; grant: index of current or last owner.
package cachepkg;
  typedef enum logic [1:0] {OP_READ, OP_WRITE, OP_FLUSH, OP_NOP} inst_t;
endpackage

module cache_arbiter #(
  parameter int DATAWIDTH = 8,
  parameter int ADDRESSWIDTH = 32
) (
  input  logic                    clock,
  input  logic                    reset,
  input  logic                    r0_request,
  input  cachepkg::inst_t         r0_operation,
  input  logic [ADDRESSWIDTH-1:0] r0_addr,
  input  logic [DATAWIDTH-1:0]    r0_wdata,
  output logic                    r0_valid,
  output logic                    r0_evict,
  output logic [DATAWIDTH-1:0]    r0_rdata,
  input  logic                    r1_request,
  input  cachepkg::inst_t         r1_operation,
  input  logic [ADDRESSWIDTH-1:0] r1_addr,
  input  logic [DATAWIDTH-1:0]    r1_wdata,
  output logic                    r1_valid,
  output logic                    r1_evict,
  output logic [DATAWIDTH-1:0]    r1_rdata,
  output logic                    c_request,
  output cachepkg::inst_t         c_operation,
  output logic [ADDRESSWIDTH-1:0] c_addr,
  output logic [DATAWIDTH-1:0]    c_wdata,
  input  logic [DATAWIDTH-1:0]    c_rdata,
  input  logic                    c_valid,
  input  logic                    c_evict,
  output logic                    grant
);
  typedef enum logic [1:0] {IDLE, ISSUE, RESPOND, RELEASE} state_t;
  state_t state_q, state_d;
  logic grant_q, grant_d, evict_q, evict_d, win, req_w;
  cachepkg::inst_t op_q, op_d;
  logic [ADDRESSWIDTH-1:0] addr_q, addr_d;
  logic [DATAWIDTH-1:0] wdata_q, wdata_d, r0_rdata_q, r0_rdata_d, r1_rdata_q, r1_rdata_d;
  assign win = (r0_request && r1_request) ? ~grant_q : r1_request;
  assign req_w = grant_q ? r1_request : r0_request;
  always_comb begin
    state_d = state_q;
    grant_d = grant_q;
    op_d = op_q;
    addr_d = addr_q;
    wdata_d = wdata_q;
    evict_d = evict_q;
    r0_rdata_d = r0_rdata_q;
    r1_rdata_d = r1_rdata_q;
    case (state_q)
      // c_valid gate lets a transaction abandoned by reset drain before the next issue
      IDLE: if ((r0_request || r1_request) && !c_valid) begin
        state_d = ISSUE;
        grant_d = win;
        op_d = win ? r1_operation : r0_operation;
        addr_d = win ? r1_addr : r0_addr;
        wdata_d = win ? r1_wdata : r0_wdata;
      end
      ISSUE: if (c_valid) begin
        state_d = req_w ? RESPOND : RELEASE;
        evict_d = req_w ? c_evict : evict_q;
        r0_rdata_d = (req_w && !grant_q) ? c_rdata : r0_rdata_q;
        r1_rdata_d = (req_w && grant_q) ? c_rdata : r1_rdata_q;
      end
      RESPOND: state_d = req_w ? RESPOND : RELEASE;
      RELEASE: state_d = c_valid ? RELEASE : IDLE;
    endcase
  end
  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= IDLE;
      grant_q <= 1'b1;
      op_q <= cachepkg::OP_READ;
      addr_q <= '0;
      wdata_q <= '0;
      evict_q <= 1'b0;
      r0_rdata_q <= '0;
      r1_rdata_q <= '0;
    end else begin
      state_q <= state_d;
      grant_q <= grant_d;
      op_q <= op_d;
      addr_q <= addr_d;
      wdata_q <= wdata_d;
      evict_q <= evict_d;
      r0_rdata_q <= r0_rdata_d;
      r1_rdata_q <= r1_rdata_d;
    end
  end
  assign c_request = (state_q == ISSUE) || (state_q == RESPOND);
  assign r0_valid = (state_q == RESPOND) && !grant_q;
  assign r1_valid = (state_q == RESPOND) && grant_q;
  assign r0_evict = r0_valid && evict_q;
  assign r1_evict = r1_valid && evict_q;
  assign r0_rdata = r0_rdata_q;
  assign r1_rdata = r1_rdata_q;
  assign c_operation = op_q;
  assign c_addr = addr_q;
  assign c_wdata = wdata_q;
  assign grant = grant_q;
endmodule

// File: tb/tb_cache_arbiter.sv
// tb_cache_arbiter: scoreboard bench for cache_arbiter with a behavioural cache
module tb_cache_arbiter;
  typedef struct {logic g; logic [31:0] a; logic [7:0] w; cachepkg::inst_t op;} iss_t;
  typedef struct {logic id; logic [7:0] d; logic ev;} rsp_t;
  typedef struct {int lat; logic [7:0] d; logic ev; int hold;} cch_t;
  logic clock, reset;
  logic r0_request, r1_request, r0_valid, r1_valid, r0_evict, r1_evict;
  cachepkg::inst_t r0_operation, r1_operation, c_operation;
  logic [31:0] r0_addr, r1_addr, c_addr;
  logic [7:0] r0_wdata, r1_wdata, r0_rdata, r1_rdata, c_wdata, c_rdata;
  logic c_request, c_valid, c_evict, grant;
  iss_t iq[$];
  rsp_t rq[$];
  cch_t cq[$];
  int total = 0, bad = 0;
  cache_arbiter #(.DATAWIDTH(8), .ADDRESSWIDTH(32)) dut (
    .clock(clock), .reset(reset),
    .r0_request(r0_request), .r0_operation(r0_operation), .r0_addr(r0_addr), .r0_wdata(r0_wdata),
    .r0_valid(r0_valid), .r0_evict(r0_evict), .r0_rdata(r0_rdata),
    .r1_request(r1_request), .r1_operation(r1_operation), .r1_addr(r1_addr), .r1_wdata(r1_wdata),
    .r1_valid(r1_valid), .r1_evict(r1_evict), .r1_rdata(r1_rdata),
    .c_request(c_request), .c_operation(c_operation), .c_addr(c_addr), .c_wdata(c_wdata),
    .c_rdata(c_rdata), .c_valid(c_valid), .c_evict(c_evict), .grant(grant)
  );
  initial begin
    clock = 0;
    forever #5 clock = ~clock;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want finish");
    $fatal(1, "watchdog");
  end
  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h want %0h", nm, act, exp);
    end
  endtask
  initial begin
    cch_t r;
    c_valid = 0;
    c_evict = 0;
    c_rdata = 0;
    forever begin
      @(negedge clock);
      if (c_request && !c_valid) begin
        if (cq.size() == 0) begin
          chk("cache_q_empty", 1, 0);
          r = '{2, 8'h00, 1'b0, 0};
        end else r = cq.pop_front();
        repeat (r.lat) @(negedge clock);
        c_valid = 1;
        c_rdata = r.d;
        c_evict = r.ev;
        while (c_request) @(negedge clock);
        repeat (r.hold) @(negedge clock);
        c_valid = 0;
        c_evict = 0;
      end
    end
  end
  initial forever begin
    @(negedge clock);
    if (!r0_request) begin r0_addr = $urandom; r0_wdata = 8'($urandom); end
    if (!r1_request) begin r1_addr = $urandom; r1_wdata = 8'($urandom); end
  end
  logic p_creq = 0, p_v0 = 0, p_v1 = 0;
  logic [31:0] p_addr;
  logic [7:0] p_wdata;
  cachepkg::inst_t p_op;
  always @(negedge clock) begin
    iss_t e;
    rsp_t q;
    if (c_request && p_creq) begin
      chk("stable_addr", c_addr, p_addr);
      chk("stable_wdata", c_wdata, p_wdata);
      chk("stable_op", c_operation, p_op);
    end
    if (c_request && !p_creq) begin
      if (iq.size() == 0) chk("issue_unexpected", 1, 0);
      else begin
        e = iq.pop_front();
        chk("issue_grant", grant, e.g);
        chk("issue_addr", c_addr, e.a);
        chk("issue_wdata", c_wdata, e.w);
        chk("issue_op", c_operation, e.op);
      end
    end
    if (r0_valid && !p_v0) begin
      if (rq.size() == 0) chk("r0_valid_unexpected", 1, 0);
      else begin
        q = rq.pop_front();
        chk("rsp_id_r0", 0, q.id);
        chk("r0_rdata", r0_rdata, q.d);
        chk("r0_evict", r0_evict, q.ev);
        chk("r1_valid_quiet", r1_valid, 0);
        chk("r1_evict_quiet", r1_evict, 0);
      end
    end
    if (r1_valid && !p_v1) begin
      if (rq.size() == 0) chk("r1_valid_unexpected", 1, 0);
      else begin
        q = rq.pop_front();
        chk("rsp_id_r1", 1, q.id);
        chk("r1_rdata", r1_rdata, q.d);
        chk("r1_evict", r1_evict, q.ev);
        chk("r0_valid_quiet", r0_valid, 0);
        chk("r0_evict_quiet", r0_evict, 0);
      end
    end
    p_creq = c_request;
    p_v0 = r0_valid;
    p_v1 = r1_valid;
    p_addr = c_addr;
    p_wdata = c_wdata;
    p_op = c_operation;
  end
  task automatic do_reset();
    @(negedge clock);
    reset = 0;
    repeat (2) @(negedge clock);
    reset = 1;
  endtask
  task automatic do_req(input bit n, input logic [31:0] a, input logic [7:0] w, input cachepkg::inst_t op);
    int i;
    @(negedge clock);
    if (n) begin r1_addr = a; r1_wdata = w; r1_operation = op; r1_request = 1; end
    else begin r0_addr = a; r0_wdata = w; r0_operation = op; r0_request = 1; end
    for (i = 0; i < 400; i++) begin
      @(negedge clock);
      if (n ? r1_valid : r0_valid) break;
    end
    chk("req_served", i < 400, 1);
    if (n) r1_request = 0; else r0_request = 0;
    for (i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!(n ? r1_valid : r0_valid)) break;
    end
    chk("valid_fall_lat", i, 0);
  endtask
  initial begin
    int i;
    reset = 0;
    r0_request = 0;
    r1_request = 0;
    r0_operation = cachepkg::OP_READ;
    r1_operation = cachepkg::OP_READ;
    do_reset();
    reset = 0;
    @(negedge clock);
    chk("rst_c_request", c_request, 0);
    chk("rst_valids", {r0_valid, r1_valid}, 0);
    chk("rst_evicts", {r0_evict, r1_evict}, 0);
    chk("rst_grant", grant, 1);
    chk("rst_addr", c_addr, 0);
    chk("rst_wdata", c_wdata, 0);
    chk("rst_rdata", {r0_rdata, r1_rdata}, 0);
    reset = 1;
    iq.push_back('{1'b0, 32'h0000_0010, 8'h00, cachepkg::OP_READ});
    rq.push_back('{1'b0, 8'hA5, 1'b0});
    cq.push_back('{3, 8'hA5, 1'b0, 0});
    @(negedge clock);
    r0_addr = 32'h0000_0010;
    r0_wdata = 8'h00;
    r0_operation = cachepkg::OP_READ;
    r0_request = 1;
    @(negedge clock);
    chk("single_creq_lat", c_request, 1);
    chk("single_no_valid_yet", r0_valid, 0);
    for (i = 0; i < 50; i++) begin
      @(posedge clock);
      if (c_valid) break;
    end
    chk("single_cvalid_seen", i < 50, 1);
    @(negedge clock);
    chk("single_valid_lat", r0_valid, 1);
    chk("single_rdata", r0_rdata, 8'hA5);
    r0_request = 0;
    @(negedge clock);
    chk("single_creq_fall", c_request, 0);
    chk("single_valid_fall", r0_valid, 0);
    repeat (2) @(negedge clock);
    chk("single_idle_creq", c_request, 0);
    chk("single_idle_cvalid", c_valid, 0);
    iq.push_back('{1'b0, 32'h0000_0020, 8'h21, cachepkg::OP_WRITE});
    cq.push_back('{4, 8'h77, 1'b1, 0});
    @(negedge clock);
    r0_addr = 32'h0000_0020;
    r0_wdata = 8'h21;
    r0_operation = cachepkg::OP_WRITE;
    r0_request = 1;
    @(negedge clock);
    chk("viol_creq", c_request, 1);
    r0_request = 0;
    for (i = 0; i < 50; i++) begin
      @(posedge clock);
      if (c_valid) break;
    end
    chk("viol_cvalid_seen", i < 50, 1);
    @(negedge clock);
    chk("viol_release_creq", c_request, 0);
    chk("viol_no_valid", r0_valid, 0);
    chk("viol_no_evict", r0_evict, 0);
    chk("viol_rdata_hold", r0_rdata, 8'hA5);
    repeat (3) @(negedge clock);
    do_reset();
    iq.push_back('{1'b0, 32'h0000_00A0, 8'h0A, cachepkg::OP_READ});
    iq.push_back('{1'b1, 32'h0000_00B0, 8'h0B, cachepkg::OP_WRITE});
    rq.push_back('{1'b0, 8'h5A, 1'b0});
    rq.push_back('{1'b1, 8'hC3, 1'b0});
    cq.push_back('{2, 8'h5A, 1'b0, 0});
    cq.push_back('{3, 8'hC3, 1'b0, 0});
    fork
      do_req(0, 32'h0000_00A0, 8'h0A, cachepkg::OP_READ);
      do_req(1, 32'h0000_00B0, 8'h0B, cachepkg::OP_WRITE);
    join
    for (int k = 0; k < 3; k++) begin
      iq.push_back('{1'b0, 32'h100 + 32'(k * 4), 8'h10 + 8'(k), cachepkg::OP_WRITE});
      iq.push_back('{1'b1, 32'h200 + 32'(k * 4), 8'h20 + 8'(k), cachepkg::OP_READ});
    end
    rq.push_back('{1'b0, 8'h11, 1'b0}); cq.push_back('{1, 8'h11, 1'b0, 0});
    rq.push_back('{1'b1, 8'h22, 1'b0}); cq.push_back('{10, 8'h22, 1'b0, 0});
    rq.push_back('{1'b0, 8'h33, 1'b0}); cq.push_back('{4, 8'h33, 1'b0, 0});
    rq.push_back('{1'b1, 8'h44, 1'b1}); cq.push_back('{7, 8'h44, 1'b1, 0});
    rq.push_back('{1'b0, 8'h55, 1'b0}); cq.push_back('{2, 8'h55, 1'b0, 0});
    rq.push_back('{1'b1, 8'h66, 1'b0}); cq.push_back('{5, 8'h66, 1'b0, 0});
    fork
      for (int k = 0; k < 3; k++) do_req(0, 32'h100 + 32'(k * 4), 8'h10 + 8'(k), cachepkg::OP_WRITE);
      for (int k = 0; k < 3; k++) do_req(1, 32'h200 + 32'(k * 4), 8'h20 + 8'(k), cachepkg::OP_READ);
    join
    repeat (3) @(negedge clock);
    iq.push_back('{1'b0, 32'h0000_0300, 8'h30, cachepkg::OP_READ});
    rq.push_back('{1'b0, 8'h3C, 1'b0});
    cq.push_back('{2, 8'h3C, 1'b0, 4});
    iq.push_back('{1'b1, 32'h0000_0400, 8'h40, cachepkg::OP_WRITE});
    rq.push_back('{1'b1, 8'h4D, 1'b1});
    cq.push_back('{3, 8'h4D, 1'b1, 0});
    @(negedge clock);
    r0_addr = 32'h0000_0300;
    r0_wdata = 8'h30;
    r0_operation = cachepkg::OP_READ;
    r0_request = 1;
    for (i = 0; i < 50; i++) begin
      @(negedge clock);
      if (r0_valid) break;
    end
    chk("rstmid_respond", i < 50, 1);
    reset = 0;
    r0_request = 0;
    r1_addr = 32'h0000_0400;
    r1_wdata = 8'h40;
    r1_operation = cachepkg::OP_WRITE;
    r1_request = 1;
    @(negedge clock);
    reset = 1;
    chk("rstmid_r0_valid", r0_valid, 0);
    chk("rstmid_c_request", c_request, 0);
    chk("rstmid_r0_evict", r0_evict, 0);
    for (i = 0; i < 20; i++) begin
      @(negedge clock);
      if (!c_valid) break;
      chk("rstmid_wait_cvalid", c_request, 0);
    end
    chk("rstmid_cvalid_drop", i < 20, 1);
    for (i = 0; i < 60; i++) begin
      @(negedge clock);
      if (r1_valid) break;
    end
    chk("rstmid_r1_served", i < 60, 1);
    r1_request = 0;
    repeat (4) @(negedge clock);
    chk("end_r1_valid", r1_valid, 0);
    chk("end_iq", iq.size(), 0);
    chk("end_rq", rq.size(), 0);
    chk("end_cq", cq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
